tau_mac_lanes: RTL and testbench



---
 rtl/tau_pkg.sv | 23 ++
 rtl/tau_lead_one.sv | 27 ++
 rtl/tau_mac_lanes.sv | 127 ++++++++++++
 tb/tb_tau_mac_lanes.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tau_pkg.sv
// Shared types and helpers for the tau MAC row.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, lane slicing helper, accumulator width check.
package tau_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OUT  = 2'd2
   } tau_mac_state_e;

   // LSB position of lane 'lane' in a packed vector of 'width'-bit lanes.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

   // A b lane shifted by up to bitwidth-1 places must fit the accumulator.
   function automatic bit acc_width_ok(input int bitwidth, input int acc_width);
      return acc_width >= 2 * bitwidth;
   endfunction

endpackage

// File: rtl/tau_lead_one.sv
// Priority encoder: index of the highest set bit of vec, any width >= 2.
// Latency: combinational.
// Backpressure: none.
// Ports: vec (in), idx (out, highest set bit, 0 when vec==0), found (out, vec != 0).
module tau_lead_one #(
   parameter int BITWIDTH = 8
) (
   input  logic [BITWIDTH-1:0]         vec,
   output logic [$clog2(BITWIDTH)-1:0] idx,
   output logic                        found
);

   localparam int IDX_W = $clog2(BITWIDTH);

   // Ascending scan: later (higher) set bits overwrite earlier ones.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < BITWIDTH; i++) begin
         if (vec[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tau_mac_lanes.sv
// Tau MAC: unary-serial a broadcast to LANES binary b lanes, per-lane dot-product accumulate.
// Latency: accept edge + max(1, popcount(a)) RUN cycles; result valid the cycle after the final RUN edge.
// Backpressure: in_ready only in IDLE; completed result held in OUT until out_ready.
// Ports: clk, reset (sync, active high); in_valid/in_ready/in_a/in_b/in_last operand side;
//        out_valid/out_ready/out_acc result side; busy = RUN or OUT.
module tau_mac_lanes
   import tau_pkg::*;
#(
   parameter int BITWIDTH  = 8,
   parameter int LANES     = 4,
   parameter int ACC_WIDTH = 2*BITWIDTH+4,
   parameter int B_SIGNED  = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [BITWIDTH-1:0]         in_a,
   input  logic [LANES*BITWIDTH-1:0]   in_b,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*ACC_WIDTH-1:0]  out_acc,
   output logic                        busy
);

   localparam int IDX_W  = $clog2(BITWIDTH);
   localparam bit ACC_OK = acc_width_ok(BITWIDTH, ACC_WIDTH);

   if (!ACC_OK) begin : g_bad_acc_width
      $error("tau_mac_lanes: ACC_WIDTH must be at least 2*BITWIDTH");
   end

   tau_mac_state_e state_q, state_d;

   logic [BITWIDTH-1:0]       a_rem_q;
   logic [LANES*BITWIDTH-1:0] b_q;
   logic                      last_q;

   logic [IDX_W-1:0]    lead_idx;
   logic                lead_found;
   logic [BITWIDTH-1:0] lead_mask;
   logic [BITWIDTH-1:0] a_rem_next;
   logic                add_en;
   logic                clear_acc;

   tau_lead_one #(.BITWIDTH(BITWIDTH)) u_lead_one (
      .vec   (a_rem_q),
      .idx   (lead_idx),
      .found (lead_found)
   );

   // With a_rem == 0 the mask is bit 0, so a_rem_next stays 0 and the
   // single empty RUN cycle is also the final one.
   assign lead_mask  = {{(BITWIDTH-1){1'b0}}, 1'b1} << lead_idx;
   assign a_rem_next = a_rem_q & ~lead_mask;

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      add_en    = 1'b0;
      clear_acc = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            busy   = 1'b1;
            add_en = lead_found;
            if (a_rem_next == '0) state_d = last_q ? OUT : IDLE;
         end
         OUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               clear_acc = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_rem_q <= '0;
         b_q     <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && in_valid) begin
            a_rem_q <= in_a;
            b_q     <= in_b;
            last_q  <= in_last;
         end else if (state_q == RUN) begin
            a_rem_q <= a_rem_next;
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [BITWIDTH-1:0]  b_lane;
      logic                 ext_bit;
      logic [ACC_WIDTH-1:0] b_ext;
      logic [ACC_WIDTH-1:0] acc_q;

      assign b_lane  = b_q[lane_lsb(i, BITWIDTH) +: BITWIDTH];
      assign ext_bit = (B_SIGNED != 0) ? b_lane[BITWIDTH-1] : 1'b0;
      assign b_ext   = {{(ACC_WIDTH-BITWIDTH){ext_bit}}, b_lane};

      // Accumulation wraps modulo 2^ACC_WIDTH by construction.
      always_ff @(posedge clk) begin
         if (reset || clear_acc) begin
            acc_q <= '0;
         end else if (add_en) begin
            acc_q <= acc_q + (b_ext << lead_idx);
         end
      end

      assign out_acc[lane_lsb(i, ACC_WIDTH) +: ACC_WIDTH] = acc_q;
   end

endmodule

// File: tb/tb_tau_mac_lanes.sv
// Bench for tau_mac_lanes: three instances (default, 16-bit accumulators, signed b)
// run in lockstep from shared stimulus; a scoreboard queue per instance holds the
// expected result vectors, and a negedge monitor compares on each out handshake.
module tb_tau_mac_lanes;

   logic clk = 1'b0;
   logic reset;
   logic in_valid;
   logic [7:0]  in_a;
   logic [31:0] in_b;
   logic in_last;
   logic out_ready;

   logic rdy_d, vld_d, busy_d;
   logic rdy_w, vld_w, busy_w;
   logic rdy_s, vld_s, busy_s;
   logic [79:0] acc_d;
   logic [63:0] acc_w;
   logic [79:0] acc_s;

   logic [79:0] q_def[$];
   logic [63:0] q_wrap[$];
   logic [79:0] q_sgn[$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tau_mac_lanes u_def (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_d), .in_a(in_a),
      .in_b(in_b), .in_last(in_last), .out_valid(vld_d), .out_ready(out_ready),
      .out_acc(acc_d), .busy(busy_d)
   );

   tau_mac_lanes #(.ACC_WIDTH(16)) u_wrap (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w), .in_a(in_a),
      .in_b(in_b), .in_last(in_last), .out_valid(vld_w), .out_ready(out_ready),
      .out_acc(acc_w), .busy(busy_w)
   );

   tau_mac_lanes #(.B_SIGNED(1)) u_sgn (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s), .in_a(in_a),
      .in_b(in_b), .in_last(in_last), .out_valid(vld_s), .out_ready(out_ready),
      .out_acc(acc_s), .busy(busy_s)
   );

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [79:0] pack20(input logic [19:0] l3, input logic [19:0] l2,
                                          input logic [19:0] l1, input logic [19:0] l0);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [63:0] pack16(input logic [15:0] l3, input logic [15:0] l2,
                                          input logic [15:0] l1, input logic [15:0] l0);
      return {l3, l2, l1, l0};
   endfunction

   task automatic push_exp(input logic [79:0] d, input logic [63:0] w, input logic [79:0] s);
      q_def.push_back(d);
      q_wrap.push_back(w);
      q_sgn.push_back(s);
   endtask

   // Monitor: a handshake completes at the next posedge when both are high here.
   always @(negedge clk) begin
      if (!reset && vld_d && out_ready) begin
         if (q_def.size() == 0) chk("def unexpected out_valid", {79'd0, vld_d}, 80'd0);
         else chk("def out_acc", acc_d, q_def.pop_front());
      end
      if (!reset && vld_w && out_ready) begin
         if (q_wrap.size() == 0) chk("wrap unexpected out_valid", {79'd0, vld_w}, 80'd0);
         else chk("wrap out_acc", {16'd0, acc_w}, {16'd0, q_wrap.pop_front()});
      end
      if (!reset && vld_s && out_ready) begin
         if (q_sgn.size() == 0) chk("sgn unexpected out_valid", {79'd0, vld_s}, 80'd0);
         else chk("sgn out_acc", acc_s, q_sgn.pop_front());
      end
   end

   // Issue one pair, then count RUN cycles until IDLE (in_ready) or OUT (out_valid).
   task automatic send(input logic [7:0] a, input logic [31:0] b, input logic last,
                       input string nm);
      int n;
      int exp_len;
      bit acc_ok;
      bit done;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      acc_ok   = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (rdy_d) begin
            acc_ok = 1'b1;
            break;
         end
      end
      if (!acc_ok) begin
         chk({nm, " accept timeout"}, 80'd0, 80'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n    = 0;
      done = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (rdy_d || vld_d) begin
            done = 1'b1;
            break;
         end
         n++;
      end
      exp_len = (a == 8'd0) ? 1 : $countones(a);
      chk({nm, " run finished"}, {79'd0, done}, 80'd1);
      chk({nm, " run length"}, 80'(n), 80'(exp_len));
      chk({nm, " ends in OUT"}, {79'd0, vld_d}, {79'd0, last});
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (rdy_d && !vld_d) begin
            ok = 1'b1;
            break;
         end
      end
      chk({nm, " back to idle"}, {79'd0, ok}, 80'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen_vld;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_a      = 8'd0;
      in_b      = 32'd0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset in_ready", {79'd0, rdy_d}, 80'd1);
      chk("reset out_valid", {79'd0, vld_d}, 80'd0);
      chk("reset busy", {79'd0, busy_d}, 80'd0);
      chk("reset acc def", acc_d, 80'd0);
      chk("reset acc wrap", {16'd0, acc_w}, 80'd0);

      // Single pair a=0xB, lanes b={4,3,2,1}
      push_exp(pack20(44, 33, 22, 11), pack16(44, 33, 22, 11), pack20(44, 33, 22, 11));
      send(8'h0B, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, "t1");

      // Two-pair stream: 3*5 + 128*1 = 143 per lane, no result between pairs
      push_exp(pack20(143, 143, 143, 143), pack16(143, 143, 143, 143),
               pack20(143, 143, 143, 143));
      send(8'h03, {4{8'd5}}, 1'b0, "t2a");
      send(8'h80, {4{8'd1}}, 1'b1, "t2b");

      // a=0: one empty RUN cycle, zero result; next stream starts from 0
      push_exp(80'd0, 64'd0, 80'd0);
      send(8'h00, {4{8'd9}}, 1'b1, "t3");
      push_exp(pack20(4, 3, 2, 1), pack16(4, 3, 2, 1), pack20(4, 3, 2, 1));
      send(8'h01, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, "t3b");

      // Two pairs 0xFF*0xFF: 130050; 16-bit wraps to 64514; signed b=-1 gives -510
      push_exp(pack20(130050, 130050, 130050, 130050),
               pack16(64514, 64514, 64514, 64514),
               pack20(20'hFFE02, 20'hFFE02, 20'hFFE02, 20'hFFE02));
      send(8'hFF, {4{8'hFF}}, 1'b0, "t4a");
      send(8'hFF, {4{8'hFF}}, 1'b1, "t4b");

      // a=5, lanes {0xFD,0x02,0x80,0x7F}: signed lanes -15, 10, -640, 635
      push_exp(pack20(1265, 10, 640, 635), pack16(1265, 10, 640, 635),
               pack20(20'hFFFF1, 10, 20'hFFD80, 635));
      send(8'h05, {8'hFD, 8'h02, 8'h80, 8'h7F}, 1'b1, "t5");

      // Backpressure: result held 5 cycles while in_valid is offered and ignored
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      push_exp(pack20(18, 16, 14, 12), pack16(18, 16, 14, 12), pack20(18, 16, 14, 12));
      send(8'h02, {8'd9, 8'd8, 8'd7, 8'd6}, 1'b1, "t6");
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         in_a     = 8'h07;
         in_b     = {4{8'd1}};
         in_last  = 1'b1;
         @(negedge clk);
         chk("t6 held acc", acc_d, pack20(18, 16, 14, 12));
         chk("t6 held out_valid", {79'd0, vld_d}, 80'd1);
         chk("t6 in_ready low", {79'd0, rdy_d}, 80'd0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_idle("t6");

      // Reset during RUN discards the partial stream
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a     = 8'hFF;
      in_b     = {4{8'd1}};
      in_last  = 1'b1;
      @(negedge clk);
      chk("t7 accept ready", {79'd0, rdy_d}, 80'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("t7 in_ready after reset", {79'd0, rdy_d}, 80'd1);
      chk("t7 busy after reset", {79'd0, busy_d}, 80'd0);
      chk("t7 acc def after reset", acc_d, 80'd0);
      chk("t7 acc sgn after reset", acc_s, 80'd0);
      seen_vld = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (vld_d || busy_d) seen_vld = 1'b1;
      end
      chk("t7 no output after reset", {79'd0, seen_vld}, 80'd0);

      // Fresh stream after reset
      push_exp(pack20(4, 3, 2, 1), pack16(4, 3, 2, 1), pack20(4, 3, 2, 1));
      send(8'h01, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, "t8");

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 80'(q_def.size() + q_wrap.size() + q_sgn.size()), 80'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
